// File: rtl/cache_rd_arbiter_pkg.sv
// Shared types and AXI constants for the icache/dcache refill read arbiter.
// One outstanding AXI read at a time; rd_req_t carries the latched winner.
package cache_rd_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, AR, R, RET} state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic       ICACHE_ID  = 1'b0;
  localparam logic       DCACHE_ID  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        uncache;
    logic        id;
  } rd_req_t;

  // Line fetches align to 16 bytes, uncached 64-bit fetches to 8 bytes.
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic uncache);
    return addr & (uncache ? 32'hFFFF_FFF8 : 32'hFFFF_FFF0);
  endfunction

endpackage

// File: rtl/cache_rd_arbiter_rr_arb2.sv
// Two-input round-robin grant; combinational grant, last_grant updates only when a grant is taken.
// Latency 0; a requester that loses simply keeps requesting until it wins.
module cache_rd_arbiter_rr_arb2
  import cache_rd_arbiter_pkg::*;
(
  input  logic       clk_g,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt
);

  logic last_grant;

  // Contested: whoever did not win last time; otherwise the sole requester.
  always_comb begin
    gnt = req[1];
    if (req == 2'b11) gnt = ~last_grant;
  end

  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      last_grant <= DCACHE_ID;
    end else if (update) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI4 read channel between icache and dcache refills; 4-beat line or 2-beat uncached burst.
// Latency: arvalid 1 cycle after grant, ret_valid 1 cycle after rlast; stalls on arready/rvalid.
module cache_rd_arbiter
  import cache_rd_arbiter_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int LINE_BEATS = 4,
  parameter int UNC_BEATS  = 2
) (
  input  logic                clk_g,
  input  logic                resetn,
  input  logic                i_rd_req,
  input  logic                i_rd_uncache,
  input  logic [31:0]         i_rd_addr,
  output logic                i_rd_rdy,
  output logic                i_ret_valid,
  output logic [127:0]        i_ret_data,
  input  logic                d_rd_req,
  input  logic                d_rd_uncache,
  input  logic [31:0]         d_rd_addr,
  output logic                d_rd_rdy,
  output logic                d_ret_valid,
  output logic [127:0]        d_ret_data,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  state_t       state;
  rd_req_t      win_req;
  logic         win_id;
  logic         grant_id;
  logic         arb_update;
  logic [1:0]   beat_cnt;
  logic [127:0] line_buf;
  logic [127:0] line_nxt;
  logic         unused_sink;

  assign arb_update = (state == IDLE) && (i_rd_req || d_rd_req);

  cache_rd_arbiter_rr_arb2 u_rr_arb2 (
    .clk_g  (clk_g),
    .resetn (resetn),
    .req    ({d_rd_req, i_rd_req}),
    .update (arb_update),
    .gnt    (win_id)
  );

  always_comb begin
    win_req         = '0;
    win_req.id      = win_id;
    win_req.addr    = win_id ? d_rd_addr : i_rd_addr;
    win_req.uncache = win_id ? d_rd_uncache : i_rd_uncache;
  end

  // Beats enter at the top, so an N-beat burst ends up in the upper N words.
  assign line_nxt = {rdata, line_buf[127:32]};

  // Accept is tied to the AR handshake itself so the cache sees it in the same cycle.
  assign i_rd_rdy = arvalid && arready && (grant_id == ICACHE_ID);
  assign d_rd_rdy = arvalid && arready && (grant_id == DCACHE_ID);

  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      state       <= IDLE;
      grant_id    <= ICACHE_ID;
      beat_cnt    <= '0;
      line_buf    <= '0;
      arvalid     <= 1'b0;
      arid        <= '0;
      araddr      <= '0;
      arlen       <= '0;
      arsize      <= '0;
      arburst     <= '0;
      rready      <= 1'b0;
      i_ret_valid <= 1'b0;
      d_ret_valid <= 1'b0;
      i_ret_data  <= '0;
      d_ret_data  <= '0;
    end else begin
      i_ret_valid <= 1'b0;
      d_ret_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_update) begin
            grant_id <= win_req.id;
            arvalid  <= 1'b1;
            arid     <= ID_WIDTH'(win_req.id);
            araddr   <= align_addr(win_req.addr, win_req.uncache);
            arlen    <= win_req.uncache ? 8'(UNC_BEATS - 1) : 8'(LINE_BEATS - 1);
            arsize   <= SIZE_4B;
            arburst  <= BURST_INCR;
            state    <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            beat_cnt <= '0;
            state    <= R;
          end
        end
        R: begin
          if (rvalid) begin
            line_buf <= line_nxt;
            if (beat_cnt != 2'd3) beat_cnt <= beat_cnt + 2'd1;
            if (rlast) begin
              rready <= 1'b0;
              state  <= RET;
              if (grant_id == ICACHE_ID) begin
                i_ret_valid <= 1'b1;
                i_ret_data  <= line_nxt;
              end else begin
                d_ret_valid <= 1'b1;
                d_ret_data  <= line_nxt;
              end
            end
          end
        end
        RET: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response id/status carry no information here; the low word is always shifted out.
  assign unused_sink = ^{rid, rresp, beat_cnt, line_buf[31:0]};

endmodule
